// File: rtl/fxp_fp_pkg.sv
// Shared constants, float layout and helpers for the fixed-point to float converter.
package fxp_fp_pkg;

    localparam int unsigned FP_EXP_BIAS = 127;
    localparam int unsigned FP_FRAC_W   = 23;
    localparam int unsigned FP_EXP_W    = 8;
    localparam int unsigned FP_W        = 32;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fxp2fp_pipe_lzc_norm.sv
// Leading-one position and left-normalising shifter; the hidden bit is dropped from norm_o.
module lzc_norm #(
    parameter int unsigned W  = 14,
    parameter int unsigned PW = 4
) (
    input  logic [W-1:0]  mag_i,
    output logic [W-2:0]  norm_o,
    output logic [PW-1:0] lead_o,
    output logic          zero_o
);
    localparam int unsigned NW = W - 1;

    logic [PW-1:0] shamt;

    always_comb begin
        lead_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (mag_i[i]) lead_o = PW'(i);
        end
        shamt  = PW'(W - 1) - lead_o;
        norm_o = NW'(mag_i << shamt);
        zero_o = (mag_i == '0);
    end

endmodule

// File: rtl/fxp2fp_pipe.sv
// Three-stage fixed-point to IEEE-754 single converter with valid/ready and collapsing bubbles.
module fxp2fp_pipe
    import fxp_fp_pkg::*;
#(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned FRAC_W = 0,
    parameter bit          SIGNED = 1'b1,
    parameter bit          RND    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out,
    output logic            out_inexact
);
    localparam int unsigned PW    = clog2(IN_W);
    localparam int unsigned NW    = IN_W - 1;
    localparam int unsigned EXT_W = NW + FP_FRAC_W + 1;

    logic            s1_v_q, s1_sign_q, s1_sign_d;
    logic [IN_W-1:0] s1_mag_q, s1_mag_d;
    logic            s2_v_q, s2_sign_q, s2_zero_q, s2_zero_d;
    logic [NW-1:0]   s2_norm_q, s2_norm_d;
    logic [PW-1:0]   s2_p_q, s2_p_d;
    logic            out_v_q, inexact_q, inexact_d;
    fp32_t           out_q, out_d;

    logic stall, accept, en1, en2, en3;

    // A stage may load whenever its own slot is empty or its contents move on.
    assign stall     = out_v_q & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & ~stall;
    assign en3       = ~out_v_q | out_ready;
    assign en2       = ~s2_v_q | en3;
    assign en1       = ~s1_v_q | en2;

    assign out_valid   = out_v_q;
    assign out         = out_q;
    assign out_inexact = inexact_q;

    always_comb begin
        s1_sign_d = SIGNED & in[IN_W-1];
        s1_mag_d  = s1_sign_d ? IN_W'(-in) : in;
    end

    lzc_norm #(
        .W  (IN_W),
        .PW (PW)
    ) u_lzc_norm (
        .mag_i  (s1_mag_q),
        .norm_o (s2_norm_d),
        .lead_o (s2_p_d),
        .zero_o (s2_zero_d)
    );

    logic [EXT_W-1:0]     ext;
    logic [FP_FRAC_W-1:0] frac_t;
    logic [FP_FRAC_W:0]   frac_r;
    logic                 guard, sticky, rnd_up;

    // Bits below the 23-bit fraction become guard|sticky; short inputs pad with zeros.
    always_comb begin
        ext       = {s2_norm_q, {(FP_FRAC_W + 1){1'b0}}};
        frac_t    = ext[EXT_W-1 -: FP_FRAC_W];
        guard     = ext[EXT_W-FP_FRAC_W-1];
        sticky    = |ext[EXT_W-FP_FRAC_W-2:0];
        rnd_up    = RND & guard & (sticky | frac_t[0]);
        frac_r    = {1'b0, frac_t} + (FP_FRAC_W + 1)'(rnd_up);
        inexact_d = guard | sticky;
        out_d.sign = s2_sign_q;
        out_d.exp  = FP_EXP_W'(FP_EXP_BIAS) + FP_EXP_W'(s2_p_q) - FP_EXP_W'(FRAC_W)
                   + FP_EXP_W'(frac_r[FP_FRAC_W]);
        out_d.frac = frac_r[FP_FRAC_W-1:0];
        if (s2_zero_q) begin
            out_d     = '0;
            inexact_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_norm_q <= '0;
            s2_p_q    <= '0;
            out_v_q   <= 1'b0;
            out_q     <= '0;
            inexact_q <= 1'b0;
        end else begin
            if (en1) begin
                s1_v_q <= accept;
                if (accept) begin
                    s1_sign_q <= s1_sign_d;
                    s1_mag_q  <= s1_mag_d;
                end
            end
            if (en2) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_sign_q <= s1_sign_q;
                    s2_zero_q <= s2_zero_d;
                    s2_norm_q <= s2_norm_d;
                    s2_p_q    <= s2_p_d;
                end
            end
            if (en3) begin
                out_v_q <= s2_v_q;
                if (s2_v_q) begin
                    out_q     <= out_d;
                    inexact_q <= inexact_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fxp2fp_pipe.sv
// Bench for fxp2fp_pipe: five parameterisations, vector table, scoreboard, backpressure and reset.
module tb_fxp2fp_pipe;

    localparam int unsigned ND = 5;

    typedef struct {
        int unsigned k;
        logic [63:0] din;
        logic [31:0] e;
        logic        ei;
    } vec_t;

    typedef struct {
        int unsigned k;
        logic [31:0] e;
        logic        ei;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   din = '0;
    logic [ND-1:0] vld = '0;
    logic [ND-1:0] ordy = '1;
    logic [ND-1:0] ird, ovld, inx;
    logic [31:0]   ov [ND];

    int passed = 0;
    int total  = 0;
    sb_t sbq[$];
    vec_t tv[$];

    logic [ND-1:0] held_v = '0;
    logic [31:0]   held_o [ND];
    logic [ND-1:0] held_x = '0;

    always #5 clk = ~clk;

    fxp2fp_pipe #(.IN_W(14), .FRAC_W(0), .SIGNED(1'b1), .RND(1'b1)) d0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ird[0]), .in(din[13:0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .out(ov[0]), .out_inexact(inx[0]));
    fxp2fp_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(1'b1), .RND(1'b1)) d1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ird[1]), .in(din[31:0]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .out(ov[1]), .out_inexact(inx[1]));
    fxp2fp_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(1'b1), .RND(1'b0)) d2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ird[2]), .in(din[31:0]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .out(ov[2]), .out_inexact(inx[2]));
    fxp2fp_pipe #(.IN_W(14), .FRAC_W(4), .SIGNED(1'b1), .RND(1'b1)) d3 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(ird[3]), .in(din[13:0]),
        .out_valid(ovld[3]), .out_ready(ordy[3]), .out(ov[3]), .out_inexact(inx[3]));
    fxp2fp_pipe #(.IN_W(14), .FRAC_W(0), .SIGNED(1'b0), .RND(1'b1)) d4 (
        .clk(clk), .rst(rst), .in_valid(vld[4]), .in_ready(ird[4]), .in(din[13:0]),
        .out_valid(ovld[4]), .out_ready(ordy[4]), .out(ov[4]), .out_inexact(inx[4]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Exact reference for the 14-bit signed, integer instance (every 14-bit value fits a float).
    function automatic logic [31:0] ref14(input logic [13:0] v);
        logic signed [13:0] sv;
        int val, m, p;
        logic s;
        sv  = v;
        val = int'(sv);
        if (val == 0) return 32'h0;
        s = (val < 0);
        m = s ? -val : val;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return {s, 8'(127 + p), 23'((m - (1 << p)) << (23 - p))};
    endfunction

    // Called at posedge+1; returns at the posedge+1 after acceptance.
    task automatic send(input int unsigned k, input logic [63:0] v, input logic [31:0] e, input logic ei);
        int n;
        din    = v;
        vld[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ird[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ird[k]) chk("accept_timeout", 64'(ird[k]), 64'd1);
        else sbq.push_back('{k, e, ei});
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pop on transfer, hold-stable while stalled, in_ready law.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            held_v = '0;
        end else begin
            for (int k = 0; k < ND; k++) begin
                if (held_v[k]) chk($sformatf("stall_hold_d%0d", k), {31'd0, ovld[k], inx[k], ov[k]},
                                   {31'd0, 1'b1, held_x[k], held_o[k]});
                chk($sformatf("in_ready_d%0d", k), 64'(ird[k]), 64'(!(ovld[k] && !ordy[k])));
                if (ovld[k] && ordy[k]) begin
                    if (sbq.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_out_d%0d: got %h expected none", k, ov[k]);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_dut", 64'(k), 64'(e.k));
                        chk($sformatf("out_d%0d", k), 64'(ov[k]), 64'(e.e));
                        chk($sformatf("inexact_d%0d", k), 64'(inx[k]), 64'(e.ei));
                    end
                end
                held_v[k] = ovld[k] & ~ordy[k];
                held_o[k] = ov[k];
                held_x[k] = inx[k];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit t5_done;
        logic [13:0] rv;

        tv.push_back('{0, 64'h0576,     32'h44AEC000, 1'b0});
        tv.push_back('{0, 64'h3576,     32'hC528A000, 1'b0});
        tv.push_back('{0, 64'h2000,     32'hC6000000, 1'b0});
        tv.push_back('{0, 64'h0000,     32'h00000000, 1'b0});
        tv.push_back('{0, 64'h0001,     32'h3F800000, 1'b0});
        tv.push_back('{0, 64'h3FFF,     32'hBF800000, 1'b0});
        tv.push_back('{0, 64'h1FFF,     32'h45FFF800, 1'b0});
        tv.push_back('{1, 64'h01000001, 32'h4B800000, 1'b1});
        tv.push_back('{1, 64'h01000003, 32'h4B800002, 1'b1});
        tv.push_back('{1, 64'h01FFFFFF, 32'h4C000000, 1'b1});
        tv.push_back('{1, 64'h02000003, 32'h4C000001, 1'b1});
        tv.push_back('{1, 64'h80000000, 32'hCF000000, 1'b0});
        tv.push_back('{1, 64'h00FFFFFF, 32'h4B7FFFFF, 1'b0});
        tv.push_back('{1, 64'hFFFFFFFF, 32'hBF800000, 1'b0});
        tv.push_back('{1, 64'h00000000, 32'h00000000, 1'b0});
        tv.push_back('{2, 64'h01000003, 32'h4B800001, 1'b1});
        tv.push_back('{2, 64'h01FFFFFF, 32'h4BFFFFFF, 1'b1});
        tv.push_back('{2, 64'h02000003, 32'h4C000000, 1'b1});
        tv.push_back('{3, 64'h0018,     32'h3FC00000, 1'b0});
        tv.push_back('{3, 64'h3FF8,     32'hBF000000, 1'b0});
        tv.push_back('{3, 64'h0001,     32'h3D800000, 1'b0});
        tv.push_back('{4, 64'h3FFF,     32'h467FFC00, 1'b0});
        tv.push_back('{4, 64'h0000,     32'h00000000, 1'b0});
        tv.push_back('{4, 64'h0001,     32'h3F800000, 1'b0});

        repeat (2) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_valid_d%0d", k), 64'(ovld[k]), 64'd0);
            chk($sformatf("rst_out_d%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_inexact_d%0d", k), 64'(inx[k]), 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(ird), 64'(5'b11111));
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) send(tv[i].k, tv[i].din, tv[i].e, tv[i].ei);
        drain();
        @(posedge clk);
        #1;

        // Latency: out_valid appears on the third edge counting the accepting edge.
        din    = 64'h0576;
        vld[0] = 1'b1;
        @(negedge clk);
        chk("lat_ready", 64'(ird[0]), 64'd1);
        sbq.push_back('{0, 32'h44AEC000, 1'b0});
        @(posedge clk);
        #1 vld[0] = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (ovld[0]) break;
        end
        chk("latency", 64'(lat), 64'd3);
        drain();
        @(posedge clk);
        #1;

        // Random backpressure on a back-to-back stream.
        t5_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    rv = 14'($urandom);
                    send(0, 64'(rv), ref14(rv), 1'b0);
                end
                t5_done = 1'b1;
            end
            begin
                while (!t5_done) begin
                    ordy[0] = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        for (int c = 0; c < 12; c++) begin
            ordy[0] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b1;
        drain();
        @(posedge clk);
        #1;

        // Reset with three samples in flight discards them all.
        send(0, 64'h0001, 32'h3F800000, 1'b0);
        send(0, 64'h0002, 32'h40000000, 1'b0);
        send(0, 64'h0003, 32'h40400000, 1'b0);
        chk("t6_inflight_valid", 64'(ovld[0]), 64'd1);
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("t6_valid_cleared", 64'(ovld[0]), 64'd0);
        chk("t6_out_cleared", 64'(ov[0]), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_no_stale", 64'(ovld[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0, 64'h3576, 32'hC528A000, 1'b0);
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
